// File: rtl/dma_device_port.sv
// Device-side port of a DMA transfer: requests the channel, then streams a write pattern out or folds read data into an XOR checksum.
// Latency: start -> LOAD -> RQST takes two edges; each beat is one cycle; DONE/ERROR each last one cycle before IDLE.
// Backpressure: dma_ack gates every beat; a burst pause drops dev_ack for WAIT_CYC cycles; stalls are bounded by TIMEOUT.
//
// Ports:
//   clk, reset                  single rising-edge clock, synchronous active-high reset
//   start                       begin a transfer (only honoured in IDLE)
//   in_num_words / in_start_address / in_rd_wr / in_seed   request descriptor, sampled while in LOAD
//   dma_ack, dma_end_flag, dev_in                          DMA-side handshake and read data
//   num_words / start_address / rd_wr                      latched descriptor
//   rqst, dev_ack, dev_ready, error, busy                  handshake and status
//   dev_out, words_done, checksum                          write data, beat count, XOR of read data
module dma_device_port #(
   parameter int DATA     = 8,
   parameter int ADD      = 7,
   parameter int WORD     = 5,
   parameter int BURST    = 4,
   parameter int WAIT_CYC = 2,
   parameter int TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD:0]     in_num_words,
   input  logic [ADD-1:0]    in_start_address,
   input  logic              in_rd_wr,
   input  logic [DATA-1:0]   in_seed,
   input  logic              dma_ack,
   input  logic              dma_end_flag,
   input  logic [DATA-1:0]   dev_in,
   output logic [WORD:0]     num_words,
   output logic [ADD-1:0]    start_address,
   output logic              rd_wr,
   output logic              rqst,
   output logic              dev_ack,
   output logic              dev_ready,
   output logic              error,
   output logic              busy,
   output logic [DATA-1:0]   dev_out,
   output logic [WORD:0]     words_done,
   output logic [DATA-1:0]   checksum
);

   // A zero-length pause would never leave PAUSE cleanly, so it is stretched to one cycle.
   localparam int WAIT_EFF = (WAIT_CYC == 0) ? 1 : WAIT_CYC;
   localparam int BW       = (BURST > 0) ? $clog2(BURST + 1) : 1;
   localparam int WW       = $clog2(WAIT_EFF + 1);
   localparam int TW       = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RQST  = 3'd2,
      XFER  = 3'd3,
      PAUSE = 3'd4,
      DRAIN = 3'd5,
      DONE  = 3'd6,
      ERROR = 3'd7
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [DATA-1:0] seed;
   logic [BW-1:0]   burst_cnt;
   logic [WW-1:0]   wait_cnt;
   logic [TW-1:0]   tmo_cnt;

   logic            rqst_nxt;
   logic            dev_ack_nxt;
   logic            dev_ready_nxt;
   logic            busy_nxt;
   logic            error_nxt;

   // dev_ack is high exactly while in XFER, so this is the beat definition.
   logic            beat;
   logic [WORD:0]   wd_inc;
   logic [BW-1:0]   burst_inc;
   logic            last_beat;
   logic            burst_hit;
   logic            wait_hit;
   logic            tmo_hit;

   assign beat      = dev_ack && dma_ack;
   assign wd_inc    = words_done + 1'b1;
   assign burst_inc = burst_cnt + 1'b1;
   assign last_beat = beat && (wd_inc == num_words);
   assign burst_hit = (BURST > 0) && beat && (burst_inc == BW'(BURST));
   assign wait_hit  = (wait_cnt == WW'(WAIT_EFF - 1));
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

   // Next state. Ordering inside XFER encodes the per-cycle priority:
   // completion beat, then burst pause, then end flag, then timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD:  state_nxt = (in_num_words == '0) ? DONE : RQST;
         RQST: begin
            if (dma_ack)      state_nxt = XFER;
            else if (tmo_hit) state_nxt = ERROR;
         end
         XFER: begin
            if (last_beat)                   state_nxt = DRAIN;
            else if (burst_hit)              state_nxt = PAUSE;
            else if (!beat && dma_end_flag)  state_nxt = DONE;
            else if (!beat && tmo_hit)       state_nxt = ERROR;
         end
         PAUSE: begin
            if (dma_end_flag)  state_nxt = DONE;
            else if (wait_hit) state_nxt = XFER;
         end
         DRAIN: begin
            if (dma_end_flag)  state_nxt = DONE;
            else if (tmo_hit)  state_nxt = ERROR;
         end
         DONE:    state_nxt = IDLE;
         ERROR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so that the flops
   // line up with the state they describe.
   always_comb begin
      rqst_nxt      = (state_nxt == RQST);
      dev_ack_nxt   = (state_nxt == XFER);
      dev_ready_nxt = (state_nxt == DONE);
      busy_nxt      = (state_nxt != IDLE);
      error_nxt     = error;
      if (state == LOAD)       error_nxt = 1'b0;
      if (state_nxt == ERROR)  error_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         rqst          <= 1'b0;
         dev_ack       <= 1'b0;
         dev_ready     <= 1'b0;
         busy          <= 1'b0;
         error         <= 1'b0;
         num_words     <= '0;
         start_address <= '0;
         rd_wr         <= 1'b0;
         seed          <= '0;
         dev_out       <= '0;
         words_done    <= '0;
         checksum      <= '0;
         burst_cnt     <= '0;
         wait_cnt      <= '0;
         tmo_cnt       <= '0;
      end else begin
         state     <= state_nxt;
         rqst      <= rqst_nxt;
         dev_ack   <= dev_ack_nxt;
         dev_ready <= dev_ready_nxt;
         busy      <= busy_nxt;
         error     <= error_nxt;
         case (state)
            LOAD: begin
               num_words     <= in_num_words;
               start_address <= in_start_address;
               rd_wr         <= in_rd_wr;
               seed          <= in_seed;
               dev_out       <= '0;
               words_done    <= '0;
               checksum      <= '0;
               burst_cnt     <= '0;
               wait_cnt      <= '0;
               tmo_cnt       <= '0;
            end
            RQST: begin
               if (dma_ack) begin
                  tmo_cnt <= '0;
                  // First write word is presented on the first XFER cycle.
                  dev_out <= rd_wr ? '0 : seed;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            XFER: begin
               if (beat) begin
                  words_done <= wd_inc;
                  tmo_cnt    <= '0;
                  burst_cnt  <= burst_hit ? '0 : burst_inc;
                  if (rd_wr) checksum <= checksum ^ dev_in;
                  else       dev_out  <= seed + DATA'(wd_inc);
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            PAUSE: wait_cnt <= wait_hit ? '0 : wait_cnt + 1'b1;
            DRAIN: tmo_cnt  <= tmo_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_device_port.sv
module tb_dma_device_port;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [5:0] in_num_words;
   logic [6:0] in_start_address;
   logic       in_rd_wr;
   logic [7:0] in_seed;
   logic       dma_ack;
   logic       dma_end_flag;
   logic [7:0] dev_in;
   logic [5:0] num_words;
   logic [6:0] start_address;
   logic       rd_wr;
   logic       rqst, dev_ack, dev_ready, error, busy;
   logic [7:0] dev_out;
   logic [5:0] words_done;
   logic [7:0] checksum;

   dma_device_port dut (
      .clk(clk), .reset(reset), .start(start),
      .in_num_words(in_num_words), .in_start_address(in_start_address),
      .in_rd_wr(in_rd_wr), .in_seed(in_seed),
      .dma_ack(dma_ack), .dma_end_flag(dma_end_flag), .dev_in(dev_in),
      .num_words(num_words), .start_address(start_address), .rd_wr(rd_wr),
      .rqst(rqst), .dev_ack(dev_ack), .dev_ready(dev_ready), .error(error), .busy(busy),
      .dev_out(dev_out), .words_done(words_done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] wd;
      logic [7:0] cs;
      logic [5:0] num;
      logic [6:0] addr;
      logic       rd;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] data_q[$];
   logic [7:0] rd_vals[$];
   int         beat_cyc[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         rqst_cyc;
   int         done_cyc;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rqst"}, rqst, 0);
      chk({tag, "_dev_ack"}, dev_ack, 0);
      chk({tag, "_dev_ready"}, dev_ready, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_dev_out"}, dev_out, 0);
      chk({tag, "_words_done"}, words_done, 0);
      chk({tag, "_checksum"}, checksum, 0);
      chk({tag, "_desc"}, {num_words, start_address, rd_wr}, 0);
   endtask

   // Drives one transfer from IDLE to DONE/ERROR. dma_ack is offered for
   // ack_beats beats; once the expected beats are in, dma_end_flag is raised.
   task automatic do_xfer(input logic rd, input logic [5:0] num, input logic [6:0] addr,
                          input logic [7:0] seed, input int ack_beats, input bit exp_err);
      exp_t e;
      int   nb;
      int   beats;
      bit   done;
      logic [7:0] cs;
      nb = exp_err ? 0 : ((ack_beats < int'(num)) ? ack_beats : int'(num));
      cs = 8'h00;
      for (int i = 0; i < nb; i++) begin
         if (rd) begin
            cs ^= rd_vals[i];
            data_q.push_back(8'h00);
         end else begin
            data_q.push_back(seed + 8'(i));
         end
      end
      e.wd = 6'(nb); e.cs = cs; e.num = num; e.addr = addr; e.rd = rd; e.err = exp_err;
      exp_q.push_back(e);
      beat_cyc.delete();
      rqst_cyc = 0;
      done_cyc = -1;
      beats = 0;
      done = 0;

      in_rd_wr = rd; in_num_words = num; in_start_address = addr; in_seed = seed;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();

      for (int c = 0; c < 200 && !done; c++) begin
         if (dev_ready || error) begin
            e = exp_q.pop_front();
            chk("end_kind", error, e.err);
            chk("busy_at_end", busy, 1);
            chk("words_done", words_done, e.wd);
            chk("checksum", checksum, e.cs);
            chk("desc_latched", {num_words, start_address, rd_wr}, {e.num, e.addr, e.rd});
            done_cyc = c;
            dma_ack = 1'b0;
            dma_end_flag = 1'b0;
            tick();
            chk("busy_after", busy, 0);
            chk("ready_pulse", dev_ready, 0);
            chk("err_sticky", error, e.err);
            chk("wd_hold", words_done, e.wd);
            done = 1;
         end else begin
            if (rqst) rqst_cyc++;
            dma_ack      = !exp_err && (beats < ack_beats);
            dma_end_flag = !exp_err && (beats >= nb);
            dev_in       = 8'hA5;
            if (dev_ack && dma_ack) begin
               chk("beat_expected", beats < nb, 1);
               if (data_q.size() > 0) chk("dev_out", dev_out, data_q.pop_front());
               if (rd && rd_vals.size() > 0) dev_in = rd_vals.pop_front();
               beat_cyc.push_back(c);
               beats++;
            end
            tick();
         end
      end
      chk("xfer_done", done, 1);
      chk("beats", beats, nb);
      dma_ack = 1'b0;
      dma_end_flag = 1'b0;
      data_q.delete();
      rd_vals.delete();
      exp_q.delete();
   endtask

   initial begin
      int beats;
      reset = 1'b1; start = 1'b0; in_num_words = '0; in_start_address = '0;
      in_rd_wr = 1'b0; in_seed = '0; dma_ack = 1'b0; dma_end_flag = 1'b0; dev_in = '0;
      repeat (3) tick();
      check_zero("rst");
      reset = 1'b0;

      // Write of 6 words, dma_ack held: pause of 2 cycles after beat 4.
      do_xfer(1'b0, 6'd6, 7'h15, 8'h0A, 6, 1'b0);
      chk("w6_rqst_seen", rqst_cyc, 1);
      if (beat_cyc.size() == 6) begin
         chk("w6_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
         chk("w6_pause_gap", beat_cyc[4] - beat_cyc[3], 3);
         chk("w6_after_pause", beat_cyc[5] - beat_cyc[4], 1);
      end
      chk("w6_done_cycle", done_cyc, 10);

      // No grant: times out in RQST after 16 cycles.
      do_xfer(1'b1, 6'd4, 7'h33, 8'h00, 0, 1'b1);
      chk("tmo_rqst_cycles", rqst_cyc, 16);

      // Read of 3 words; also shows the sticky error cleared by LOAD.
      rd_vals = '{8'h11, 8'h22, 8'h44};
      do_xfer(1'b1, 6'd3, 7'h40, 8'h00, 3, 1'b0);
      chk("rd3_checksum_const", checksum, 8'h77);

      // Exactly one burst: completion wins over the pause, pattern wraps.
      do_xfer(1'b0, 6'd4, 7'h7F, 8'hFE, 4, 1'b0);
      chk("w4_done_cycle", done_cyc, 6);

      // Short transfer: DMA ends after 5 of 8 beats.
      do_xfer(1'b0, 6'd8, 7'h01, 8'h50, 5, 1'b0);
      chk("short_wd_const", words_done, 5);

      // Longer random read crossing two pauses.
      for (int i = 0; i < 10; i++) rd_vals.push_back(8'($urandom_range(0, 255)));
      do_xfer(1'b1, 6'd10, 7'h2A, 8'h00, 10, 1'b0);

      // Reset in the middle of XFER after two beats.
      in_rd_wr = 1'b0; in_num_words = 6'd8; in_start_address = 7'h11; in_seed = 8'h30;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      beats = 0;
      for (int c = 0; c < 50 && beats < 2; c++) begin
         dma_ack = 1'b1;
         if (dev_ack) beats++;
         tick();
      end
      chk("mid_beats", words_done, 2);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      tick();
      check_zero("midrst");
      reset = 1'b0;
      dma_ack = 1'b0;

      // Zero-length request straight after reset: DONE after LOAD, no rqst.
      do_xfer(1'b0, 6'd0, 7'h05, 8'h99, 0, 1'b0);
      chk("zero_no_rqst", rqst_cyc, 0);
      chk("zero_done_cycle", done_cyc, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dma_device_port.md
DMA_DEVICE_PORT -- requirements
Module: dma_device_port

Interface
REQ-001 SHALL: parameter DATA, default 8, data bus width.
REQ-002 SHALL: parameter ADD, default 7, start-address width.
REQ-003 SHALL: parameter WORD, default 5; word count is WORD+1 bits.
REQ-004 SHALL: parameter BURST, default 4, beats per burst before a pause; 0 means no pauses.
REQ-005 SHALL: parameter WAIT_CYC, default 2, pause length in cycles (value 0 treated as 1).
REQ-006 SHALL: parameter TIMEOUT, default 16, maximum idle-handshake cycles before error.
REQ-007 SHALL: clk  in  1  single clock, all logic on rising edge.
REQ-008 SHALL: reset  in  1  synchronous, active-high.
REQ-009 SHALL: start  in  1  begin a transfer (sampled in IDLE only).
REQ-010 SHALL: in_num_words  in  WORD+1  words to transfer.
REQ-011 SHALL: in_start_address  in  ADD  memory start address.
REQ-012 SHALL: in_rd_wr  in  1  1 = read (memory to device), 0 = write (device to memory).
REQ-013 SHALL: in_seed  in  DATA  first word of write pattern.
REQ-014 SHALL: dma_ack  in  1  DMA grant / beat strobe.
REQ-015 SHALL: dma_end_flag  in  1  DMA completed memory side.
REQ-016 SHALL: dev_in  in  DATA  read data from DMA.
REQ-017 SHALL: num_words, start_address, rd_wr  out  WORD+1, ADD, 1  latched request descriptor.
REQ-018 SHALL: rqst, dev_ack, dev_ready, error, busy  out  1 each  handshake/status.
REQ-019 SHALL: dev_out  out  DATA  write data; words_done  out  WORD+1  beat count; checksum  out  DATA  XOR of read data.

Function
REQ-020 SHALL: FSM states IDLE, LOAD, RQST, XFER, PAUSE, DRAIN, DONE, ERROR; all outputs registered; dev_out never high-Z.
REQ-021 SHALL: IDLE: start=1 -> LOAD next cycle; start ignored in every other state.
REQ-022 SHALL: LOAD (1 cycle): latch descriptor and in_seed, clear words_done, checksum, burst/wait/timeout counters; -> DONE if in_num_words==0, else RQST.
REQ-023 SHALL: RQST: rqst=1 until dma_ack sampled 1 -> XFER; timeout counter runs, reaching TIMEOUT -> ERROR.
REQ-024 SHALL: XFER: dev_ack=1; a beat is any cycle with dma_ack=1 and dev_ack=1; each beat increments words_done and burst counter, clears timeout counter.
REQ-025 SHALL: write mode: dev_out = seed + words_done (mod 2^DATA) from first XFER cycle, advancing on the cycle after each beat; read mode: dev_in sampled on beat, checksum ^= dev_in; dev_out = 0 in read mode.
REQ-026 SHALL: beat making words_done == num_words -> DRAIN (takes priority over burst pause).
REQ-027 SHALL: beat making burst counter == BURST (BURST>0) with words remaining -> PAUSE, burst counter cleared.
REQ-028 SHALL: PAUSE: dev_ack=0, dev_out held, for WAIT_CYC cycles -> XFER; dma_ack during PAUSE is not a beat.
REQ-029 SHALL: XFER/PAUSE with dma_end_flag=1 and no beat in that cycle -> DONE (short transfer, words_done < num_words retained).
REQ-030 SHALL: XFER with dma_ack=0: stall, no beat; TIMEOUT consecutive stall cycles -> ERROR.
REQ-031 SHALL: DRAIN: dev_ack=0; dma_end_flag=1 -> DONE; TIMEOUT cycles without it -> ERROR.
REQ-032 SHALL: DONE: dev_ready=1 for exactly one cycle, -> IDLE.
REQ-033 SHALL: ERROR: one cycle -> IDLE; error output set on entry, sticky until next LOAD or reset.
REQ-034 SHALL: busy=1 in all states except IDLE; descriptor, words_done, checksum hold after DONE/ERROR until next LOAD.
REQ-035 SHALL: priority per cycle: reset > completion beat > burst pause > dma_end_flag > timeout.

Reset
REQ-036 SHALL: reset=1 at a clock edge forces IDLE and zeroes every output and counter, including mid-transfer; error cleared.
REQ-037 SHALL: after reset release, first start accepted on the next edge.

Verification
REQ-038 SHALL: write, num=6, seed=0x0A, dma_ack held 1, end_flag 1 after DRAIN -> dev_out 0x0A..0x0F, pause of 2 cycles after beat 4, dev_ready one cycle, words_done=6.
REQ-039 SHALL: read, num=3, dev_in 0x11,0x22,0x44 on beats -> checksum=0x77, DRAIN, DONE on end_flag.
REQ-040 SHALL: RQST with dma_ack never asserted -> error=1 after 16 cycles, busy=0 next cycle.
REQ-041 SHALL: write num=8, end_flag asserted after 5 beats with dma_ack=0 -> DONE, words_done=5, error=0.
REQ-042 SHALL: reset asserted during XFER after 2 beats -> next cycle all outputs 0, state IDLE; start with num=0 then -> dev_ready after LOAD with no rqst.
